lfsr_rng_stream: RTL

//  - Parametrised Fibonacci-LFSR random-number source with a valid/ready output stream.
//  - Successor to the fixed 32-bit free-running LFSR: configurable width, tap mask and decorrelation steps.
//  - Adds runtime seed load, a step enable, all-zero lock-up protection and optional range limiting.
//  - Feeds game logic (pipe-gap heights, spawn jitter); consumer pulls one word per handshake.

---
 rtl/lfsr_rng_stream_pkg.sv | 32 +++
 rtl/lfsr_rng_stream_if.sv | 32 +++
 rtl/lfsr_rng_stream_core.sv | 61 ++++++
 rtl/lfsr_rng_stream.sv | 126 ++++++++++++
 4 files changed

// File: rtl/lfsr_rng_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_pkg (file lfsr_rng_stream_pkg.sv)
//  Purpose  : Shared types and constants for the lfsr_rng_stream block:
//             output FSM state encoding, maximal-length tap masks for the
//             common widths and the default (non-zero) seed.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lfsr_pkg;

  // Output FSM: FILL shifts the LFSR, VALID holds a word for the consumer.
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_VALID = 1'b1
  } fsm_state_t;

  // Tap masks: bit i set means state[i] feeds the XOR (bit i <-> x^(i+1)).
  localparam logic [7:0]  TAPS_8  = 8'hB8;                    // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] TAPS_16 = 16'hD008;                 // x^16+x^15+x^13+x^4+1
  localparam logic [23:0] TAPS_24 = 24'hE1_0000;              // x^24+x^23+x^22+x^17+1
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;            // x^32+x^22+x^2+x+1
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;  // x^64+x^63+x^61+x^60+1

  // Reset / substitute seed; any non-zero value keeps the LFSR out of lock-up.
  localparam logic [31:0] SEED_DEFAULT = 32'h0000_0001;

  // Step counter width; covers STEPS up to 255.
  localparam int STEP_CNT_W = 8;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_rng_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_rng_stream_if
//  Purpose  : valid/ready output stream carrying one random word per transfer.
//  Signals  : out_valid  producer -> consumer, word in out_data is fresh
//             out_ready  consumer -> producer, word accepted when both high
//             out_data   OUT_W-bit random word
//  Modports : master (producer side), slave (consumer side)
//  Revision : 1.0  initial release
// ============================================================================
interface lfsr_rng_stream_if #(
  parameter int OUT_W = 8
) ();

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface : lfsr_rng_stream_if
`default_nettype wire

// File: rtl/lfsr_rng_stream_core.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_core (file lfsr_rng_stream_core.sv)
//  Purpose  : Fibonacci LFSR state register with feedback XOR, all-zero
//             lock-up guard and seed load mux.
//  Ports    : clk          clock, rising edge
//             rst          asynchronous active-high reset (state <= SEED_DEFAULT)
//             i_step       advance the LFSR by one shift
//             i_load       load i_seed (priority over i_step)
//             i_seed       seed value; zero is replaced by SEED_DEFAULT
//             o_state      current LFSR state
//             o_next_word  low OUT_W bits of the state after the next step
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(lfsr_pkg::TAPS_32),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(lfsr_pkg::SEED_DEFAULT),
  parameter int               OUT_W        = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_step,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_seed,
  output logic      [WIDTH-1:0] o_state,
  output logic      [OUT_W-1:0] o_next_word
);

  logic [WIDTH-1:0] r_state;
  logic             w_fb;
  logic             w_zero;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_seed;

  assign w_fb   = ^(r_state & TAPS);
  assign w_zero = (r_state == '0);

  // An all-zero state would shift zeros forever; the next step recovers by
  // reloading the default seed instead of shifting.
  assign w_shift = w_zero ? SEED_DEFAULT : {r_state[WIDTH-2:0], w_fb};

  assign w_seed = (i_seed == '0) ? SEED_DEFAULT : i_seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_DEFAULT;
    end else if (i_load) begin
      r_state <= w_seed;
    end else if (i_step) begin
      r_state <= w_shift;
    end
  end

  assign o_state     = r_state;
  assign o_next_word = w_shift[OUT_W-1:0];

endmodule : lfsr_core
`default_nettype wire

// File: rtl/lfsr_rng_stream.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_rng_stream
//  Purpose  : Parametrised Fibonacci-LFSR random-number source with a
//             valid/ready output stream. Each word is taken after STEPS
//             enabled shifts; runtime seed load, step enable, lock-up guard.
//  Option   : `define LFSR_RANGE_EN enables rejection sampling against
//             i_limit (exclusive bound, 0 = unlimited). Without it i_limit
//             is ignored and every fill yields a word.
//  Ports    : clk          clock, rising edge
//             rst          asynchronous active-high reset
//             i_en         step enable (freezes shifting and step count)
//             i_seed_load  one-cycle strobe: load i_seed_in
//             i_seed_in    new seed, zero replaced by SEED_DEFAULT
//             i_limit      exclusive upper bound for words (range option)
//             o_stream     master side of the output stream interface
//             o_state_dbg  current LFSR state
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_rng_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(lfsr_pkg::TAPS_32),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(lfsr_pkg::SEED_DEFAULT),
  parameter int               OUT_W        = 8,
  parameter int               STEPS        = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  input  wire logic             i_seed_load,
  input  wire logic [WIDTH-1:0] i_seed_in,
  input  wire logic [OUT_W-1:0] i_limit,
  lfsr_rng_stream_if.master     o_stream,
  output logic      [WIDTH-1:0] o_state_dbg
);

  fsm_state_t            r_fsm;
  logic [STEP_CNT_W-1:0] r_cnt;
  logic                  r_valid;
  logic [OUT_W-1:0]      r_data;

  logic                  w_step;
  logic                  w_last;
  logic                  w_accept;
  logic [OUT_W-1:0]      w_next_word;
  logic [WIDTH-1:0]      w_state;

  // The LFSR only moves while filling; a seed load overrides the step.
  assign w_step = (r_fsm == ST_FILL) && i_en && !i_seed_load;
  assign w_last = (r_cnt == STEP_CNT_W'(STEPS - 1));

`ifdef LFSR_RANGE_EN
  // Candidate is the word the LFSR will hold after this step.
  assign w_accept = (i_limit == '0) || (w_next_word < i_limit);
`else
  // Range limiting is absent: every candidate is accepted. The reduction
  // keeps the unused limit input attached to logic.
  assign w_accept = 1'b1 | (&i_limit);
`endif

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT),
    .OUT_W        (OUT_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_step      (w_step),
    .i_load      (i_seed_load),
    .i_seed      (i_seed_in),
    .o_state     (w_state),
    .o_next_word (w_next_word)
  );

  // Seed load wins over stepping and over a same-cycle handshake; the old
  // word is still considered transferred, the next one starts from the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= ST_FILL;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_seed_load) begin
      r_fsm   <= ST_FILL;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_fsm)
        ST_FILL: begin
          if (i_en) begin
            if (w_last) begin
              r_cnt <= '0;
              // A rejected candidate simply restarts the fill from the
              // already-advanced state.
              if (w_accept) begin
                r_data  <= w_next_word;
                r_valid <= 1'b1;
                r_fsm   <= ST_VALID;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_VALID: begin
          if (o_stream.out_ready) begin
            r_valid <= 1'b0;
            r_fsm   <= ST_FILL;
          end
        end
        default: begin
          r_fsm <= ST_FILL;
        end
      endcase
    end
  end

  assign o_stream.out_valid = r_valid;
  assign o_stream.out_data  = r_data;
  assign o_state_dbg        = w_state;

endmodule : lfsr_rng_stream
`default_nettype wire
